delay_req_arbiter: RTL and testbench
====================================

Name: delay_req_arbiter

Overview:
- Shares the single read/write request port of the delay-buffer master between n_req requesters (DSP cores or other engines).
- Uses round-robin arbitration and runs one transaction at a time.
- Sits between the requesters and the delay master. Routes each master response (read data/valid or write ack) back to the requester that issued the transaction.
- Reports busy, current grant and a sticky error.

Parameters:
- data_width, 16, sample, handle and increment width
- n_req, 4, number of requesters (2..16)
- timeout_cycles, 1024, WAIT-state watchdog limit (used only with the optional feature)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_read  in  n_req  per-requester read request, level, held until that requester's read_valid
- req_write  in  n_req  per-requester write request, level, held until that requester's write_ack
- req_handle  in  n_req*data_width  per-requester buffer handle, slice i = requester i
- req_write_data  in  n_req*data_width  per-requester write sample
- req_write_inc  in  n_req*data_width  per-requester write-pointer increment
- req_read_data  out  data_width  last read result, broadcast to all requesters
- req_read_valid  out  n_req  one-cycle pulse to the granted requester
- req_write_ack  out  n_req  one-cycle pulse to the granted requester
- delay_read_req  out  1  one-cycle pulse to master
- delay_write_req  out  1  one-cycle pulse to master
- delay_req_handle  out  data_width  latched handle
- delay_write_data  out  data_width  latched write data
- delay_write_inc  out  data_width  latched increment
- delay_read_data  in  data_width  master read result
- delay_read_valid  in  1  master read complete
- delay_write_ack  in  1  master write complete
- busy  out  1  high whenever state is not IDLE
- grant_idx  out  $clog2(n_req)  index of the current or last granted requester
- error  out  1  sticky protocol/timeout error

Behaviour:
- Reset (async, reset_n low):
  - state=IDLE; rr_ptr=n_req-1.
  - All outputs 0, including req_read_data, grant_idx and error.
  - Any in-flight transaction is abandoned with no response pulse. Master responses arriving after reset are ignored.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - pending[i] = req_read[i] | req_write[i].
  - Select the first pending index searching rr_ptr+1, rr_ptr+2, ... mod n_req.
  - On the clock edge: latch idx, handle, write_data and inc.
  - op = READ if req_read[idx], else WRITE. Read wins when both are set; the write is served on a later grant.
  - Assert delay_read_req or delay_write_req (registered), set grant_idx=idx, go to ISSUE.
- ISSUE: deassert the master request (exactly one-cycle pulse), go to WAIT.
- WAIT:
  - On the matching master response (delay_read_valid for READ, delay_write_ack for WRITE): register req_read_data=delay_read_data (READ only), pulse req_read_valid[idx] or req_write_ack[idx] for one cycle, set rr_ptr=idx, go to DONE.
  - A non-matching response in WAIT sets error and is otherwise ignored.
  - A master response in IDLE, ISSUE or DONE sets error.
- DONE: one dead cycle so the requester can drop its request; then IDLE.
- Latency: request sampled at edge E, master pulse in cycle E..E+1, response pulse one cycle after master response. Minimum spacing between grants is 4 cycles with a zero-wait master.
- A requester dropping its request mid-transaction has no effect; the transaction completes and the pulse is still issued.
- Latched handle and data stay stable on the master outputs from ISSUE through DONE.
- error clears only on reset.

Optional Feature:
DELAY_REQ_ARBITER_TIMEOUT_EN
- Defined:
  - A counter runs in WAIT. After timeout_cycles cycles with no matching response, abandon the transaction.
  - Pulse the requester's valid/ack with req_read_data=0, set error, set rr_ptr=idx, go to DONE.
- Undefined: WAIT holds indefinitely; no counter is synthesized.

Test Plan:
- Requester 1 reads handle 3; master returns 0x1234 two cycles after its pulse -> delay_read_req pulses once with handle 3; req_read_valid=0b0010 for one cycle; req_read_data=0x1234.
- Requesters 0, 2, 3 raise reads simultaneously from reset and hold until served -> grant order 0, 2, 3; each gets exactly one valid pulse; then requester 0 re-raises with 2 pending -> 2 served before 0.
- Requester 2 raises read and write together (write data 0x00FF, inc 1) -> read served first, then write with delay_write_data=0x00FF and inc=1; req_write_ack=0b0100.
- Spurious delay_write_ack while IDLE -> error=1; arbitration continues normally.
- reset_n low during WAIT, then release; late master valid arrives -> no response pulse, busy=0, error=0.
- With DELAY_REQ_ARBITER_TIMEOUT_EN and timeout_cycles=16, master silent -> after 16 WAIT cycles, valid pulse with data 0 and error=1. Without the macro -> busy stays 1.

Source files
------------

// File: rtl/delay_req_arbiter.sv
// ============================================================================
// Module   : delay_req_arbiter
// Function : Round-robin arbiter sharing one delay-buffer master port between
//            N_REQ requesters, one transaction at a time. The optional WAIT
//            watchdog is enabled with `define DELAY_REQ_ARBITER_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module delay_req_arbiter #(
   parameter int DATA_WIDTH     = 16,
   parameter int N_REQ          = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [N_REQ-1:0]              req_read,
   input  logic [N_REQ-1:0]              req_write,
   input  logic [N_REQ*DATA_WIDTH-1:0]   req_handle,
   input  logic [N_REQ*DATA_WIDTH-1:0]   req_write_data,
   input  logic [N_REQ*DATA_WIDTH-1:0]   req_write_inc,
   output logic [DATA_WIDTH-1:0]         req_read_data,
   output logic [N_REQ-1:0]              req_read_valid,
   output logic [N_REQ-1:0]              req_write_ack,
   output logic                          delay_read_req,
   output logic                          delay_write_req,
   output logic [DATA_WIDTH-1:0]         delay_req_handle,
   output logic [DATA_WIDTH-1:0]         delay_write_data,
   output logic [DATA_WIDTH-1:0]         delay_write_inc,
   input  logic [DATA_WIDTH-1:0]         delay_read_data,
   input  logic                          delay_read_valid,
   input  logic                          delay_write_ack,
   output logic                          busy,
   output logic [$clog2(N_REQ)-1:0]      grant_idx,
   output logic                          error
);

   localparam int IW = $clog2(N_REQ);
   localparam logic [IW:0] C_NREQ = (IW+1)'(N_REQ);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_t;

   state_t                  state_q, state_d;
   op_t                     op_q, op_d;
   logic [IW-1:0]           rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [DATA_WIDTH-1:0]   handle_q, handle_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]   inc_q, inc_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    rd_req_q, rd_req_d;
   logic                    wr_req_q, wr_req_d;
   logic [N_REQ-1:0]        rvalid_q, rvalid_d;
   logic [N_REQ-1:0]        wack_q, wack_d;
   logic                    error_q, error_d;
   logic                    quiet_q, quiet_d;

   logic [N_REQ-1:0]        pending;
   logic                    found;
   logic [IW-1:0]           sel;
   logic [IW:0]             cand;
   logic                    rsp_any;
   logic                    rsp_match;
   logic                    rsp_other;
   logic                    tmo_hit;

`ifdef DELAY_REQ_ARBITER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] C_TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;

   assign tmo_cnt_d = (state_q == S_WAIT) ? tmo_cnt_q + 1'b1 : '0;
   assign tmo_hit   = (state_q == S_WAIT) && (tmo_cnt_q == C_TMO_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end
`else
   assign tmo_hit = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

   assign pending = req_read | req_write;

   // Search order starts just after the last served requester.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      cand  = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = {1'b0, rr_ptr_q} + (IW+1)'(k);
         if (cand >= C_NREQ) begin
            cand = cand - C_NREQ;
         end
         if (!found && pending[cand[IW-1:0]]) begin
            found = 1'b1;
            sel   = cand[IW-1:0];
         end
      end
   end

   assign rsp_any   = delay_read_valid | delay_write_ack;
   assign rsp_match = (op_q == OP_READ) ? delay_read_valid : delay_write_ack;
   assign rsp_other = (op_q == OP_READ) ? delay_write_ack  : delay_read_valid;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      rr_ptr_d = rr_ptr_q;
      idx_d    = idx_q;
      handle_d = handle_q;
      wdata_d  = wdata_q;
      inc_d    = inc_q;
      rdata_d  = rdata_q;
      rd_req_d = 1'b0;
      wr_req_d = 1'b0;
      rvalid_d = '0;
      wack_d   = '0;
      error_d  = error_q;
      quiet_d  = quiet_q;

      case (state_q)
         S_IDLE: begin
            // Until the first grant after reset, stray responses belong to an
            // abandoned transaction and are dropped silently.
            if (rsp_any && !quiet_q) begin
               error_d = 1'b1;
            end
            if (found) begin
               idx_d    = sel;
               op_d     = req_read[sel] ? OP_READ : OP_WRITE;
               handle_d = req_handle[sel*DATA_WIDTH +: DATA_WIDTH];
               wdata_d  = req_write_data[sel*DATA_WIDTH +: DATA_WIDTH];
               inc_d    = req_write_inc[sel*DATA_WIDTH +: DATA_WIDTH];
               rd_req_d = req_read[sel];
               wr_req_d = ~req_read[sel];
               quiet_d  = 1'b0;
               state_d  = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (rsp_any) begin
               error_d = 1'b1;
            end
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (rsp_other) begin
               error_d = 1'b1;
            end
            if (rsp_match) begin
               if (op_q == OP_READ) begin
                  rdata_d         = delay_read_data;
                  rvalid_d[idx_q] = 1'b1;
               end else begin
                  wack_d[idx_q]   = 1'b1;
               end
               rr_ptr_d = idx_q;
               state_d  = S_DONE;
            end else if (tmo_hit) begin
               rdata_d         = '0;
               rvalid_d[idx_q] = (op_q == OP_READ);
               wack_d[idx_q]   = (op_q == OP_WRITE);
               error_d         = 1'b1;
               rr_ptr_d        = idx_q;
               state_d         = S_DONE;
            end
         end
         S_DONE: begin
            if (rsp_any) begin
               error_d = 1'b1;
            end
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         op_q     <= OP_READ;
         rr_ptr_q <= IW'(N_REQ - 1);
         idx_q    <= '0;
         handle_q <= '0;
         wdata_q  <= '0;
         inc_q    <= '0;
         rdata_q  <= '0;
         rd_req_q <= 1'b0;
         wr_req_q <= 1'b0;
         rvalid_q <= '0;
         wack_q   <= '0;
         error_q  <= 1'b0;
         quiet_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         rr_ptr_q <= rr_ptr_d;
         idx_q    <= idx_d;
         handle_q <= handle_d;
         wdata_q  <= wdata_d;
         inc_q    <= inc_d;
         rdata_q  <= rdata_d;
         rd_req_q <= rd_req_d;
         wr_req_q <= wr_req_d;
         rvalid_q <= rvalid_d;
         wack_q   <= wack_d;
         error_q  <= error_d;
         quiet_q  <= quiet_d;
      end
   end

   assign req_read_data    = rdata_q;
   assign req_read_valid   = rvalid_q;
   assign req_write_ack    = wack_q;
   assign delay_read_req   = rd_req_q;
   assign delay_write_req  = wr_req_q;
   assign delay_req_handle = handle_q;
   assign delay_write_data = wdata_q;
   assign delay_write_inc  = inc_q;
   assign busy             = (state_q != S_IDLE);
   assign grant_idx        = idx_q;
   assign error            = error_q;

endmodule

`default_nettype wire

// File: tb/tb_delay_req_arbiter.sv
// ============================================================================
// Module   : tb_delay_req_arbiter
// Function : Directed self-checking bench for delay_req_arbiter with a simple
//            fixed-latency master model and auto-dropping requesters.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_delay_req_arbiter;

   localparam int DW  = 16;
   localparam int NR  = 4;
   localparam int TMO = 16;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [NR-1:0]     req_read = '0;
   logic [NR-1:0]     req_write = '0;
   logic [NR*DW-1:0]  req_handle = '0;
   logic [NR*DW-1:0]  req_write_data = '0;
   logic [NR*DW-1:0]  req_write_inc = '0;
   logic [DW-1:0]     req_read_data;
   logic [NR-1:0]     req_read_valid;
   logic [NR-1:0]     req_write_ack;
   logic              delay_read_req;
   logic              delay_write_req;
   logic [DW-1:0]     delay_req_handle;
   logic [DW-1:0]     delay_write_data;
   logic [DW-1:0]     delay_write_inc;
   logic [DW-1:0]     delay_read_data = '0;
   logic              delay_read_valid = 1'b0;
   logic              delay_write_ack = 1'b0;
   logic              busy;
   logic [1:0]        grant_idx;
   logic              error;

   delay_req_arbiter #(
      .DATA_WIDTH     (DW),
      .N_REQ          (NR),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .req_read         (req_read),
      .req_write        (req_write),
      .req_handle       (req_handle),
      .req_write_data   (req_write_data),
      .req_write_inc    (req_write_inc),
      .req_read_data    (req_read_data),
      .req_read_valid   (req_read_valid),
      .req_write_ack    (req_write_ack),
      .delay_read_req   (delay_read_req),
      .delay_write_req  (delay_write_req),
      .delay_req_handle (delay_req_handle),
      .delay_write_data (delay_write_data),
      .delay_write_inc  (delay_write_inc),
      .delay_read_data  (delay_read_data),
      .delay_read_valid (delay_read_valid),
      .delay_write_ack  (delay_write_ack),
      .busy             (busy),
      .grant_idx        (grant_idx),
      .error            (error)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   int            glog[$];
   int            gcyc[$];
   logic [DW-1:0] hlog[$];
   bit            oplog[$];
   int            rv_cnt[NR];
   int            wa_cnt[NR];
   int            rreq_hi;
   int            wreq_hi;
   logic [DW-1:0] last_rdata;
   logic [NR-1:0] last_rv;
   logic [NR-1:0] last_wa;
   int            last_pulse_cyc;
   logic [DW-1:0] wdata_at_ack;
   logic [DW-1:0] inc_at_ack;

   int            m_lat = 1;
   bit            m_en = 1'b1;
   int            m_cnt = 0;
   bit            m_rd = 1'b0;
   logic [DW-1:0] m_rdata = '0;

   task automatic clear_logs();
      glog.delete();
      gcyc.delete();
      hlog.delete();
      oplog.delete();
      for (int i = 0; i < NR; i++) begin
         rv_cnt[i] = 0;
         wa_cnt[i] = 0;
      end
      rreq_hi = 0;
      wreq_hi = 0;
      last_rv = '0;
      last_wa = '0;
      last_pulse_cyc = -1;
   endtask

   // One clock: observe outputs, let served requesters drop, run the master.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (delay_read_req === 1'b1 || delay_write_req === 1'b1) begin
         glog.push_back(int'(grant_idx));
         gcyc.push_back(cyc);
         hlog.push_back(delay_req_handle);
         oplog.push_back(delay_write_req);
      end
      if (delay_read_req === 1'b1)  rreq_hi++;
      if (delay_write_req === 1'b1) wreq_hi++;
      if (req_read_valid !== '0) begin
         last_rv        = req_read_valid;
         last_rdata     = req_read_data;
         last_pulse_cyc = cyc;
      end
      if (req_write_ack !== '0) begin
         last_wa        = req_write_ack;
         wdata_at_ack   = delay_write_data;
         inc_at_ack     = delay_write_inc;
         last_pulse_cyc = cyc;
      end
      for (int i = 0; i < NR; i++) begin
         if (req_read_valid[i] === 1'b1) begin
            rv_cnt[i]++;
            req_read[i] = 1'b0;
         end
         if (req_write_ack[i] === 1'b1) begin
            wa_cnt[i]++;
            req_write[i] = 1'b0;
         end
      end
      delay_read_valid = 1'b0;
      delay_write_ack  = 1'b0;
      if (m_cnt > 0) begin
         m_cnt--;
         if (m_cnt == 0) begin
            if (m_rd) begin
               delay_read_valid = 1'b1;
               delay_read_data  = m_rdata;
            end else begin
               delay_write_ack = 1'b1;
            end
         end
      end
      if (m_en && (delay_read_req === 1'b1 || delay_write_req === 1'b1)) begin
         m_rd  = delay_read_req;
         m_cnt = m_lat;
      end
   endtask

   task automatic run_until(input int target, input int budget, output bit ok);
      int tot;
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         tick();
         tot = 0;
         for (int i = 0; i < NR; i++) tot += rv_cnt[i] + wa_cnt[i];
         if (tot >= target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic apply_reset();
      reset_n   = 1'b0;
      req_read  = '0;
      req_write = '0;
      m_cnt     = 0;
      m_en      = 1'b1;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick();
      tick();
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0h expected 0", busy); end
      n_tests++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %0h expected 0", error); end
      n_tests++; if (grant_idx !== 2'd0) begin n_fail++; $display("FAIL reset_grant_idx: got %0h expected 0", grant_idx); end
      n_tests++; if (req_read_data !== 16'h0) begin n_fail++; $display("FAIL reset_read_data: got %0h expected 0", req_read_data); end
      n_tests++; if (req_read_valid !== 4'h0) begin n_fail++; $display("FAIL reset_read_valid: got %0h expected 0", req_read_valid); end
      reset_n = 1'b1;
      tick();
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %0h expected 0", busy); end
      n_tests++; if (delay_read_req !== 1'b0) begin n_fail++; $display("FAIL reset_delay_read_req: got %0h expected 0", delay_read_req); end
      n_tests++; if (delay_write_req !== 1'b0) begin n_fail++; $display("FAIL reset_delay_write_req: got %0h expected 0", delay_write_req); end
      n_tests++; if (req_write_ack !== 4'h0) begin n_fail++; $display("FAIL reset_write_ack: got %0h expected 0", req_write_ack); end
      n_tests++; if (delay_req_handle !== 16'h0) begin n_fail++; $display("FAIL reset_handle: got %0h expected 0", delay_req_handle); end
      n_tests++; if (delay_write_data !== 16'h0) begin n_fail++; $display("FAIL reset_write_data: got %0h expected 0", delay_write_data); end
      n_tests++; if (delay_write_inc !== 16'h0) begin n_fail++; $display("FAIL reset_write_inc: got %0h expected 0", delay_write_inc); end
   endtask

   task automatic test_single_read();
      bit ok;
      int g0;
      clear_logs();
      m_lat   = 2;
      m_rdata = 16'h1234;
      req_handle[1*DW +: DW] = 16'd3;
      req_read[1] = 1'b1;
      run_until(1, 30, ok);
      repeat (3) tick();
      g0 = (glog.size() > 0) ? glog[0] : -1;
      n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_done: got %0d expected 1", ok); end
      n_tests++; if (glog.size() !== 1) begin n_fail++; $display("FAIL single_grants: got %0d expected 1", glog.size()); end
      n_tests++; if (g0 !== 1) begin n_fail++; $display("FAIL single_grant_idx: got %0d expected 1", g0); end
      n_tests++; if (hlog.size() < 1 || hlog[0] !== 16'd3) begin n_fail++; $display("FAIL single_handle: got %0h expected 3", (hlog.size() > 0) ? hlog[0] : 16'hxxxx); end
      n_tests++; if (rreq_hi !== 1) begin n_fail++; $display("FAIL single_req_pulse_cycles: got %0d expected 1", rreq_hi); end
      n_tests++; if (last_rv !== 4'b0010) begin n_fail++; $display("FAIL single_valid_vec: got %0b expected 0010", last_rv); end
      n_tests++; if (rv_cnt[1] !== 1) begin n_fail++; $display("FAIL single_valid_count: got %0d expected 1", rv_cnt[1]); end
      n_tests++; if (last_rdata !== 16'h1234) begin n_fail++; $display("FAIL single_read_data: got %0h expected 1234", last_rdata); end
      n_tests++; if (gcyc.size() < 1 || last_pulse_cyc - gcyc[0] !== 3) begin n_fail++; $display("FAIL single_latency: got %0d expected 3", (gcyc.size() > 0) ? last_pulse_cyc - gcyc[0] : -1); end
      n_tests++; if (error !== 1'b0) begin n_fail++; $display("FAIL single_error: got %0h expected 0", error); end
   endtask

   task automatic test_round_robin();
      bit          rer;
      int          tot;
      logic [15:0] ord;
      apply_reset();
      clear_logs();
      m_lat    = 1;
      m_rdata  = 16'h0055;
      rer      = 1'b0;
      req_read = 4'b1101;
      for (int c = 0; c < 80; c++) begin
         tick();
         if (rv_cnt[0] == 1 && !rer) begin
            req_read[0] = 1'b1;
            rer = 1'b1;
         end
         tot = 0;
         for (int i = 0; i < NR; i++) tot += rv_cnt[i];
         if (tot >= 4) break;
      end
      ord = '0;
      for (int i = 0; i < glog.size() && i < 4; i++) ord = {ord[11:0], 4'(glog[i])};
      n_tests++; if (glog.size() !== 4) begin n_fail++; $display("FAIL rr_grants: got %0d expected 4", glog.size()); end
      n_tests++; if (ord !== 16'h0230) begin n_fail++; $display("FAIL rr_order: got %0h expected 0230", ord); end
      n_tests++; if (rv_cnt[0] !== 2) begin n_fail++; $display("FAIL rr_count0: got %0d expected 2", rv_cnt[0]); end
      n_tests++; if (rv_cnt[2] !== 1 || rv_cnt[3] !== 1) begin n_fail++; $display("FAIL rr_count23: got %0d/%0d expected 1/1", rv_cnt[2], rv_cnt[3]); end
      n_tests++; if (gcyc.size() < 2 || gcyc[1] - gcyc[0] !== 4) begin n_fail++; $display("FAIL rr_spacing: got %0d expected 4", (gcyc.size() > 1) ? gcyc[1] - gcyc[0] : -1); end
   endtask

   task automatic test_read_write_same();
      bit          ok;
      logic [7:0]  ord;
      clear_logs();
      m_lat = 1;
      m_rdata = 16'h0777;
      req_handle[2*DW +: DW]     = 16'd5;
      req_write_data[2*DW +: DW] = 16'h00FF;
      req_write_inc[2*DW +: DW]  = 16'd1;
      req_read[2]  = 1'b1;
      req_write[2] = 1'b1;
      run_until(2, 40, ok);
      ord = '0;
      for (int i = 0; i < oplog.size() && i < 2; i++) ord = {ord[3:0], 3'b000, oplog[i]};
      n_tests++; if (ok !== 1'b1 || glog.size() !== 2) begin n_fail++; $display("FAIL rw_grants: got %0d expected 2", glog.size()); end
      n_tests++; if (ord !== 8'h01) begin n_fail++; $display("FAIL rw_op_order: got %0h expected 01", ord); end
      n_tests++; if (glog.size() < 2 || glog[1] !== 2) begin n_fail++; $display("FAIL rw_write_idx: got %0d expected 2", (glog.size() > 1) ? glog[1] : -1); end
      n_tests++; if (last_wa !== 4'b0100) begin n_fail++; $display("FAIL rw_ack_vec: got %0b expected 0100", last_wa); end
      n_tests++; if (wdata_at_ack !== 16'h00FF) begin n_fail++; $display("FAIL rw_write_data: got %0h expected 00ff", wdata_at_ack); end
      n_tests++; if (inc_at_ack !== 16'd1) begin n_fail++; $display("FAIL rw_write_inc: got %0h expected 1", inc_at_ack); end
      n_tests++; if (hlog.size() < 2 || hlog[1] !== 16'd5) begin n_fail++; $display("FAIL rw_handle: got %0h expected 5", (hlog.size() > 1) ? hlog[1] : 16'hxxxx); end
      n_tests++; if (rv_cnt[2] !== 1 || wa_cnt[2] !== 1) begin n_fail++; $display("FAIL rw_counts: got %0d/%0d expected 1/1", rv_cnt[2], wa_cnt[2]); end
      n_tests++; if (wreq_hi !== 1) begin n_fail++; $display("FAIL rw_write_pulse_cycles: got %0d expected 1", wreq_hi); end
   endtask

   task automatic test_spurious();
      bit ok;
      n_tests++; if (error !== 1'b0) begin n_fail++; $display("FAIL spur_pre_error: got %0h expected 0", error); end
      delay_write_ack = 1'b1;
      tick();
      n_tests++; if (error !== 1'b1) begin n_fail++; $display("FAIL spur_error: got %0h expected 1", error); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL spur_busy: got %0h expected 0", busy); end
      clear_logs();
      m_lat   = 1;
      m_rdata = 16'hA5A5;
      req_handle[3*DW +: DW] = 16'd7;
      req_read[3] = 1'b1;
      run_until(1, 30, ok);
      n_tests++; if (ok !== 1'b1 || last_rv !== 4'b1000) begin n_fail++; $display("FAIL spur_continue_vec: got %0b expected 1000", last_rv); end
      n_tests++; if (last_rdata !== 16'hA5A5) begin n_fail++; $display("FAIL spur_continue_data: got %0h expected a5a5", last_rdata); end
      n_tests++; if (error !== 1'b1) begin n_fail++; $display("FAIL spur_sticky: got %0h expected 1", error); end
   endtask

   task automatic test_reset_in_wait();
      clear_logs();
      m_lat   = 6;
      m_rdata = 16'h4321;
      req_read[1] = 1'b1;
      for (int c = 0; c < 10 && glog.size() == 0; c++) tick();
      tick();
      tick();
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstwait_pre_busy: got %0h expected 1", busy); end
      reset_n  = 1'b0;
      req_read = '0;
      #1;
      n_tests++; if (busy !== 1'b0 || error !== 1'b0) begin n_fail++; $display("FAIL rstwait_async: got busy=%0h error=%0h expected 0/0", busy, error); end
      tick();
      reset_n = 1'b1;
      repeat (8) tick();
      n_tests++; if (rv_cnt[1] !== 0) begin n_fail++; $display("FAIL rstwait_no_pulse: got %0d expected 0", rv_cnt[1]); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstwait_busy: got %0h expected 0", busy); end
      n_tests++; if (error !== 1'b0) begin n_fail++; $display("FAIL rstwait_error: got %0h expected 0", error); end
   endtask

   task automatic test_timeout();
      bit ok;
      clear_logs();
      m_en    = 1'b1;
      m_lat   = 1;
      m_rdata = 16'hBEEF;
      req_read[0] = 1'b1;
      run_until(1, 30, ok);
      n_tests++; if (ok !== 1'b1 || last_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL tmo_pre_read: got %0h expected beef", last_rdata); end
      clear_logs();
      m_en = 1'b0;
      req_read[0] = 1'b1;
`ifdef DELAY_REQ_ARBITER_TIMEOUT_EN
      run_until(1, 40, ok);
      n_tests++; if (ok !== 1'b1 || last_rv !== 4'b0001) begin n_fail++; $display("FAIL tmo_valid_vec: got %0b expected 0001", last_rv); end
      n_tests++; if (gcyc.size() < 1 || last_pulse_cyc - gcyc[0] !== TMO + 1) begin n_fail++; $display("FAIL tmo_latency: got %0d expected %0d", (gcyc.size() > 0) ? last_pulse_cyc - gcyc[0] : -1, TMO + 1); end
      n_tests++; if (last_rdata !== 16'h0) begin n_fail++; $display("FAIL tmo_data: got %0h expected 0", last_rdata); end
      n_tests++; if (error !== 1'b1) begin n_fail++; $display("FAIL tmo_error: got %0h expected 1", error); end
`else
      repeat (40) tick();
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL notmo_busy: got %0h expected 1", busy); end
      n_tests++; if (rv_cnt[0] !== 0) begin n_fail++; $display("FAIL notmo_no_pulse: got %0d expected 0", rv_cnt[0]); end
      n_tests++; if (error !== 1'b0) begin n_fail++; $display("FAIL notmo_error: got %0h expected 0", error); end
`endif
      apply_reset();
   endtask

   initial begin
      clear_logs();
      test_reset();
      test_single_read();
      test_round_robin();
      test_read_write_same();
      test_spurious();
      test_reset_in_wait();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
